// File: rtl/inst_mem_loader.sv
// Instruction RAM loader: assembles big-endian words from a UART byte stream,
// writes them through the RAM write port and holds the CPU in reset while loading.
module inst_mem_loader #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned TIMEOUT   = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_cnt
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          state, state_nx;
    logic [15:0]     len;
    logic [23:0]     asm_q;
    logic [1:0]      byte_idx;
    logic [7:0]      csum;
    logic [TO_W-1:0] to_cnt;

    logic            in_load;
    logic            take;
    logic            word_done;
    logic            last_word;
    logic            len_bad;
    logic            timed_out;
    logic [15:0]     len_full;
    logic [1:0]      set_code;

    always_comb begin
        in_load   = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DATA)   || (state == S_CSUM);
        take      = rx_valid && in_load;
        len_full  = {len[15:8], rx_data};
        len_bad   = (len_full == 16'd0) || ({16'd0, len_full} > MEM_DEPTH);
        word_done = take && (state == S_DATA) && (byte_idx == 2'd3);
        last_word = (32'(word_cnt) + 32'd1) == {16'd0, len};
        // A byte arriving on the expiry cycle still counts as in time.
        timed_out = in_load && !take && (to_cnt == TO_W'(TIMEOUT - 1));

        busy      = in_load;
        cpu_hold  = in_load || (state == S_ERROR);
        done      = (state == S_DONE);
        err       = (state == S_ERROR);
    end

    always_comb begin
        state_nx = state;
        set_code = 2'b00;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_nx = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (take) state_nx = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (take) begin
                    if (len_bad) begin
                        state_nx = S_ERROR;
                        set_code = 2'b01;
                    end else begin
                        state_nx = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_done && last_word) state_nx = S_CSUM;
            end
            S_CSUM: begin
                if (take) begin
                    if (rx_data == csum) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_ERROR;
                        set_code = 2'b10;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (timed_out) begin
            state_nx = S_ERROR;
            set_code = 2'b11;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            len       <= '0;
            asm_q     <= '0;
            byte_idx  <= '0;
            csum      <= '0;
            to_cnt    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err_code  <= '0;
            word_cnt  <= '0;
        end else begin
            state  <= state_nx;
            mem_we <= word_done;
            // The write lands one cycle after the fourth byte, together with the count.
            if (word_done) begin
                mem_addr  <= word_cnt[ADDR_W-1:0];
                mem_wdata <= {asm_q, rx_data};
                word_cnt  <= word_cnt + (ADDR_W + 1)'(1);
            end
            if (start && !in_load) begin
                len      <= '0;
                asm_q    <= '0;
                byte_idx <= '0;
                csum     <= '0;
                to_cnt   <= '0;
                err_code <= '0;
                word_cnt <= '0;
            end else if (in_load) begin
                if (take) begin
                    to_cnt <= '0;
                end else if (!timed_out) begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
                if (set_code != 2'b00) err_code <= set_code;
                if (take) begin
                    case (state)
                        S_LEN_HI: len[15:8] <= rx_data;
                        S_LEN_LO: len[7:0]  <= rx_data;
                        S_DATA: begin
                            asm_q    <= {asm_q[15:0], rx_data};
                            byte_idx <= byte_idx + 2'd1;
                            csum     <= csum ^ rx_data;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: directed scenarios plus randomized
// frames checked against a frame-level reference model and a shadow RAM.
module tb_inst_mem_loader;

    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned TIMEOUT   = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   word_cnt;

    inst_mem_loader #(
        .MEM_DEPTH(MEM_DEPTH),
        .ADDR_W   (ADDR_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  frame[$];
    int unsigned got_addr[$];
    logic [31:0] got_data[$];
    int unsigned exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] ram[MEM_DEPTH];
    logic        exp_done;
    logic        exp_err;
    logic [1:0]  exp_code;
    int unsigned exp_cnt;

    // Shadow RAM and write log built from the write port.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            got_addr.push_back(int'(mem_addr));
            got_data.push_back(mem_wdata);
            ram[mem_addr] = mem_wdata;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_start);
        rx_valid = 1'b1;
        rx_data  = b;
        start    = with_start;
        tick();
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic pulse_start(input logic with_byte);
        start    = 1'b1;
        rx_valid = with_byte;
        rx_data  = 8'hA5;
        tick();
        start    = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic make_frame(input logic [15:0] n, input logic bad_csum);
        logic [7:0] b;
        logic [7:0] x;
        frame.delete();
        frame.push_back(n[15:8]);
        frame.push_back(n[7:0]);
        if (n != 16'd0 && 32'(n) <= MEM_DEPTH) begin
            x = 8'h00;
            for (int i = 0; i < 4 * int'(n); i++) begin
                b = 8'($urandom);
                x ^= b;
                frame.push_back(b);
            end
            if (bad_csum) x ^= 8'($urandom_range(1, 255));
            frame.push_back(x);
        end
    endtask

    // Frame-level expectation straight from the frame format.
    task automatic model_frame();
        int unsigned n;
        logic [7:0]  x;
        exp_addr.delete();
        exp_data.delete();
        n = int'({frame[0], frame[1]});
        if (n == 0 || n > MEM_DEPTH) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            exp_code = 2'b01;
            exp_cnt  = 0;
        end else begin
            x = 8'h00;
            for (int w = 0; w < int'(n); w++) begin
                exp_addr.push_back(w);
                exp_data.push_back({frame[2+4*w], frame[3+4*w], frame[4+4*w], frame[5+4*w]});
                for (int k = 0; k < 4; k++) x ^= frame[2+4*w+k];
            end
            exp_cnt = n;
            if (frame[2+4*n] == x) begin
                exp_done = 1'b1;
                exp_err  = 1'b0;
                exp_code = 2'b00;
            end else begin
                exp_done = 1'b0;
                exp_err  = 1'b1;
                exp_code = 2'b10;
            end
        end
    endtask

    task automatic compare_result();
        int m;
        check("nwrites", got_addr.size(), exp_addr.size());
        m = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < m; i++) begin
            check("wr_addr", got_addr[i], exp_addr[i]);
            check("wr_data", got_data[i], exp_data[i]);
        end
        check("done", done, exp_done);
        check("err", err, exp_err);
        check("err_code", err_code, exp_code);
        check("word_cnt", word_cnt, exp_cnt);
        check("cpu_hold", cpu_hold, exp_err);
        check("busy_end", busy, 1'b0);
    endtask

    task automatic run_frame(input int max_gap, input int inject_at, input logic coincident);
        got_addr.delete();
        got_data.delete();
        pulse_start(coincident);
        check("busy_after_start", busy, 1'b1);
        check("hold_after_start", cpu_hold, 1'b1);
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i], i == inject_at);
            repeat ($urandom_range(0, max_gap)) tick();
        end
        repeat (2) tick();
        model_frame();
        compare_result();
    endtask

    task automatic check_all_zero();
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_hold", cpu_hold, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_err_code", err_code, 0);
        check("rst_word_cnt", word_cnt, 0);
    endtask

    initial begin
        int          k;
        logic [15:0] n;
        logic [31:0] w0;
        int          inj;

        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) tick();
        check_all_zero();
        reset = 1'b0;
        tick();

        // Good two-word load.
        frame = '{8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03, 8'h3c, 8'h08, 8'h40, 8'h00, 8'h7f};
        run_frame(0, -1, 1'b0);

        // Same frame with a bad checksum, then a start clears the error.
        frame[10] = 8'h7e;
        run_frame(1, -1, 1'b0);
        pulse_start(1'b0);
        check("restart_err", err, 1'b0);
        check("restart_code", err_code, 0);
        check("restart_cnt", word_cnt, 0);
        check("restart_busy", busy, 1'b1);
        check("restart_hold", cpu_hold, 1'b1);
        do_reset();

        // Length 257 rejected right after the second length byte.
        got_addr.delete();
        got_data.delete();
        pulse_start(1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        check("len_err", err, 1'b1);
        check("len_err_code", err_code, 2'b01);
        repeat (3) tick();
        check("len_nwrites", got_addr.size(), 0);

        // Zero length is also rejected.
        frame = '{8'h00, 8'h00};
        run_frame(0, -1, 1'b0);

        // Timeout after a partial word.
        got_addr.delete();
        got_data.delete();
        pulse_start(1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h08, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        k = 0;
        while (err !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        check("timeout_cycles", k, TIMEOUT);
        check("timeout_code", err_code, 2'b11);
        check("timeout_hold", cpu_hold, 1'b1);
        check("timeout_nwrites", got_addr.size(), 0);

        // start during DATA is ignored.
        make_frame(16'd3, 1'b0);
        run_frame(2, 7, 1'b0);
        // start coincident with a byte: that byte is not a length byte.
        make_frame(16'd2, 1'b0);
        run_frame(1, -1, 1'b1);
        // Back-to-back bytes, three words.
        make_frame(16'd3, 1'b0);
        run_frame(0, -1, 1'b0);

        // Reset in the middle of the second word.
        make_frame(16'd2, 1'b0);
        w0 = {frame[2], frame[3], frame[4], frame[5]};
        got_addr.delete();
        got_data.delete();
        pulse_start(1'b0);
        for (int i = 0; i < 8; i++) send_byte(frame[i], 1'b0);
        reset = 1'b1;
        tick();
        check_all_zero();
        check("reset_word0", ram[0], w0);
        check("reset_nwrites", got_addr.size(), 1);
        reset = 1'b0;
        tick();
        make_frame(16'd2, 1'b0);
        run_frame(1, -1, 1'b0);

        // Full-depth load reaches the last address.
        make_frame(16'(MEM_DEPTH), 1'b0);
        run_frame(0, -1, 1'b0);

        // Randomized frames.
        for (int t = 0; t < 10; t++) begin
            k = $urandom_range(0, 9);
            if (k == 0)      n = 16'd0;
            else if (k == 1) n = 16'($urandom_range(MEM_DEPTH + 1, 65535));
            else             n = 16'($urandom_range(1, 6));
            make_frame(n, $urandom_range(0, 3) == 0);
            inj = -1;
            if (frame.size() > 3 && $urandom_range(0, 1) == 1)
                inj = $urandom_range(2, frame.size() - 1);
            run_frame($urandom_range(0, 4), inj, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
